// File: rtl/capping_pkg.sv
// Shared types and defaults for the capping sequencer (state encoding, parameters, width helper).
package capping_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        DISPENSE = 3'd2,
        WAIT_CAP = 3'd3,
        RELEASE  = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam int DEF_MAX_STOPPERS   = 15;
    localparam int DEF_LOW_LEVEL      = 5;
    localparam int DEF_TIMEOUT_CYCLES = 1000;

    // Bits needed to hold any value in 0..max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/cap_watchdog.sv
// WAIT_CAP watchdog: counts enabled cycles after a clear and flags the last allowed cycle.
module cap_watchdog
    import capping_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WD_W = cnt_width(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_count <= '0;
        end else if (clear) begin
            wd_count <= '0;
        end else if (enable && (wd_count != LAST)) begin
            wd_count <= wd_count + WD_W'(1);
        end
    end

    assign expired = (wd_count == LAST);

endmodule

// File: rtl/capping_sequencer.sv
// Stopper dispenser / conveyor sequencer for the bottling cell.
// Optional capping watchdog and FAULT state enabled by defining CAP_TIMEOUT_EN.
module capping_sequencer
    import capping_pkg::*;
#(
    parameter int MAX_STOPPERS   = DEF_MAX_STOPPERS,
    parameter int LOW_LEVEL      = DEF_LOW_LEVEL,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = cnt_width(MAX_STOPPERS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bottle_present,
    input  logic             cap_done,
    input  logic             refill_req,
    input  logic             fault_clr,
    output logic             conveyor_run,
    output logic             disp_cmd,
    output logic [CNT_W-1:0] stopper_count,
    output logic             low_level,
    output logic             empty_alarm,
    output logic             fault,
    output logic [7:0]       bottles_capped
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STOPPERS);

    state_t state;
    state_t next_state;
    logic   refill_q;
    logic   refill_edge;
    logic   count_nz;
    logic   wd_expired;

    assign refill_edge = refill_req & ~refill_q;
    assign count_nz    = (stopper_count != '0);

`ifdef CAP_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // Clearing in DISPENSE means the count is zero on the first WAIT_CAP cycle.
    assign wd_clear  = (state == DISPENSE);
    assign wd_enable = (state == WAIT_CAP);

    cap_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_fault_clr;

    assign unused_fault_clr = fault_clr;
    assign wd_expired       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            refill_q       <= 1'b0;
            stopper_count  <= '0;
            bottles_capped <= '0;
        end else begin
            state    <= next_state;
            refill_q <= refill_req;

            if ((state == IDLE) && refill_edge && (stopper_count != CNT_MAX)) begin
                stopper_count <= stopper_count + CNT_W'(1);
            end else if (state == DISPENSE) begin
                stopper_count <= stopper_count - CNT_W'(1);
            end

            if ((state == WAIT_CAP) && cap_done) begin
                bottles_capped <= bottles_capped + 8'd1;
            end
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && count_nz) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    next_state = IDLE;
                end else if (bottle_present) begin
                    next_state = DISPENSE;
                end
            end
            DISPENSE: begin
                next_state = WAIT_CAP;
            end
            WAIT_CAP: begin
                if (cap_done) begin
                    next_state = RELEASE;
                end else if (wd_expired) begin
                    next_state = FAULT;
                end
            end
            RELEASE: begin
                if (!bottle_present) begin
                    next_state = (start && count_nz) ? RUN : IDLE;
                end
            end
            FAULT: begin
`ifdef CAP_TIMEOUT_EN
                if (fault_clr) begin
                    next_state = IDLE;
                end
`else
                next_state = IDLE;
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore outputs: asynchronous reset forces state to IDLE, so disp_cmd drops at once.
    always_comb begin
        conveyor_run = (state == RUN) || (state == RELEASE);
        disp_cmd     = (state == DISPENSE);
`ifdef CAP_TIMEOUT_EN
        fault        = (state == FAULT);
`else
        fault        = 1'b0;
`endif
    end

    assign low_level   = (32'(stopper_count) <= LOW_LEVEL);
    assign empty_alarm = !count_nz;

endmodule

// File: doc/capping_sequencer.md
# capping_sequencer

Line-level controller that sequences the stopper dispenser against the bottle conveyor in the automatic bottling cell. It tracks the stopper magazine inventory, stops the conveyor when a bottle reaches the capping position, and issues a single dispense command per bottle. It waits for seating confirmation, then releases the bottle. It accepts operator refills and raises low-level, empty and timeout-fault indications.

## Interface
- MAX_STOPPERS, 15: magazine capacity; count saturates here.
- LOW_LEVEL, 5: low_level asserts when count <= this value.
- TIMEOUT_CYCLES, 1000: WAIT_CAP watchdog limit; only used with CAP_TIMEOUT_EN.
- CNT_W, $clog2(MAX_STOPPERS+1): width of stopper_count.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  level; line run enable.
- bottle_present  in  1  capping-position sensor, already synchronised.
- cap_done  in  1  level; the capping head reports the stopper is seated.
- refill_req  in  1  operator switch; each rising edge adds one stopper.
- fault_clr  in  1  clears FAULT.
- conveyor_run  out  1  conveyor motor enable.
- disp_cmd  out  1  one-cycle dispense pulse to the dispenser.
- stopper_count  out  CNT_W  current magazine inventory.
- low_level  out  1  stopper_count <= LOW_LEVEL.
- empty_alarm  out  1  stopper_count == 0.
- fault  out  1  capping timeout occurred.
- bottles_capped  out  8  count of completed bottles; wraps 255->0.

## Operation
- FSM states: IDLE, RUN, DISPENSE, WAIT_CAP, RELEASE, FAULT. Outputs are Moore outputs of registered state and counters.
- IDLE:
  - conveyor_run=0.
  - A refill rising edge (refill_req & ~refill_q) increments count. Count saturates at MAX_STOPPERS.
  - If start=1 and the registered count != 0, go to RUN.
- RUN:
  - conveyor_run=1.
  - If start=0, go to IDLE. This check has priority.
  - Else if bottle_present=1, go to DISPENSE.
  - Refill edges are ignored.
- DISPENSE: disp_cmd=1, conveyor_run=0. Count decrements by 1. Always go to WAIT_CAP.
- WAIT_CAP:
  - conveyor_run=0.
  - On cap_done=1, bottles_capped increments and the state goes to RELEASE.
- RELEASE:
  - conveyor_run=1.
  - When bottle_present=0: go to RUN if start=1 and count != 0; otherwise go to IDLE.
- FAULT:
  - conveyor_run=0, fault=1.
  - fault_clr=1 moves to IDLE. Count is unchanged, because the stopper was consumed.
- Reset values:
  - state=IDLE; stopper_count=0; bottles_capped=0; refill_q=0; watchdog=0.
  - conveyor_run=0, disp_cmd=0, fault=0, low_level=1, empty_alarm=1.
- Boundary conditions:
  - Count never underflows: DISPENSE is only reachable with count >= 1.
  - A refill edge at count==MAX leaves the count unchanged.
  - Refill edge and start in the same IDLE cycle with count 0: count becomes 1, the state stays IDLE, and RUN follows on the next cycle.
  - Reset mid-operation aborts immediately. disp_cmd drops asynchronously, and any partially dispensed bottle is not counted.

## Timing
- bottle_present high in RUN in cycle N:
  - DISPENSE in cycle N+1, with disp_cmd high for exactly that cycle.
  - conveyor_run low from N+1.
  - stopper_count shows the decremented value from N+2.
- cap_done in WAIT_CAP in cycle M: RELEASE at M+1, bottles_capped updated at M+1.
- The refill increment is visible one cycle after the sampled edge.
- Watchdog:
  - Clears on entry to WAIT_CAP and increments each WAIT_CAP cycle.
  - When it reaches TIMEOUT_CYCLES-1 without cap_done, the next state is FAULT. FAULT is therefore entered after TIMEOUT_CYCLES cycles in WAIT_CAP.
  - If cap_done arrives in the threshold cycle, cap_done wins.

## Configuration
- CAP_TIMEOUT_EN defined: the watchdog is instantiated, FAULT is reachable, and fault and fault_clr are functional.
- CAP_TIMEOUT_EN undefined:
  - No watchdog logic; WAIT_CAP waits indefinitely for cap_done.
  - fault is tied 0 and fault_clr is ignored.
  - The FAULT encoding is kept but is unreachable; it decodes to IDLE.

## Structure
- Package capping_pkg:
  - state enum (3-bit) with encodings IDLE=0, RUN=1, DISPENSE=2, WAIT_CAP=3, RELEASE=4, FAULT=5.
  - Default parameter constants.
  - Width helper for CNT_W.
- Sub-module cap_watchdog:
  - Parameter TIMEOUT_CYCLES; inputs clear, enable; output expired.
  - Instantiated only under CAP_TIMEOUT_EN.

## Test plan
- Reset, then 3 refill edges in IDLE -> stopper_count=3, low_level=1, empty_alarm=0. A 4th edge with MAX_STOPPERS=3 -> count stays 3.
- Count=2, start=1, bottle_present pulse, cap_done 4 cycles later, bottle_present drops -> one disp_cmd pulse, count=1, bottles_capped=1, back in RUN with conveyor_run=1.
- Count=1, full bottle cycle -> count=0, empty_alarm=1, state IDLE after RELEASE, and start=1 does not restart the conveyor.
- CAP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no cap_done -> fault=1 exactly 8 cycles after WAIT_CAP entry. fault_clr -> IDLE, count retained.
- cap_done in the watchdog threshold cycle -> RELEASE, fault stays 0. Also: start dropped in RUN -> IDLE the next cycle, with no disp_cmd.
- Async reset asserted during DISPENSE -> disp_cmd and conveyor_run are 0 immediately, all counters are 0 after release, state is IDLE.
